// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake and a
// two-entry skid buffer (main entry M drives the outputs, skid entry S
// absorbs one op when downstream stalls). in_ready is registered, so there
// is no combinational ready path from downstream back to upstream.
// A synchronous flush kills both held ops and any op offered that cycle.
// out_ctrl is qualified by out_valid so a bubble never has side effects.
//
// Optional build macro: PIPE_STAGE_STATS_EN adds saturating stall and
// flush-discard counters (stat_stall, stat_flush).
module pipe_stage_reg #(
  parameter int unsigned CTRL_W   = 7,
  parameter int unsigned FLAG_W   = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_DATA = 3,
  parameter int unsigned RD_W     = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  // Upstream side
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [FLAG_W-1:0]          in_flags,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]            in_rd,
  // Downstream side
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [FLAG_W-1:0]          out_flags,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [RD_W-1:0]            out_rd
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]                stat_stall,
  output logic [15:0]                stat_flush
`endif
);

  localparam int unsigned DataBits = NUM_DATA * DATA_W;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Valid bits are kept as their own flops so every output is a plain
  // register (or a register ANDed with a register), never a state decode.
  logic m_valid_q, m_valid_d;
  logic s_valid_q, s_valid_d;
  logic in_ready_q, in_ready_d;

  // Main entry payload
  logic [CTRL_W-1:0]   m_ctrl_q;
  logic [FLAG_W-1:0]   m_flags_q;
  logic [DataBits-1:0] m_data_q;
  logic [RD_W-1:0]     m_rd_q;

  // Skid entry payload
  logic [CTRL_W-1:0]   s_ctrl_q;
  logic [FLAG_W-1:0]   s_flags_q;
  logic [DataBits-1:0] s_data_q;
  logic [RD_W-1:0]     s_rd_q;

  // Handshakes and payload load strobes
  logic acc;
  logic dq;
  logic m_load_in;
  logic m_load_skid;
  logic s_load;

  assign acc = in_valid & in_ready_q;
  assign dq  = m_valid_q & out_ready;

  // Next-state and payload-steering decisions; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    m_load_in   = 1'b0;
    m_load_skid = 1'b0;
    s_load      = 1'b0;

    if (flush) begin
      // Drop held and incoming ops; payload flops keep their contents.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            m_load_in = 1'b1;
            state_d   = StOne;
          end
        end
        StOne: begin
          if (dq && acc) begin
            m_load_in = 1'b1;
          end else if (dq) begin
            state_d = StEmpty;
          end else if (acc) begin
            s_load  = 1'b1;
            state_d = StFull;
          end
        end
        StFull: begin
          // in_ready is low here, so only a dequeue can move things.
          if (dq) begin
            m_load_skid = 1'b1;
            state_d     = StOne;
          end
        end
        default: begin
          state_d = StEmpty;
        end
      endcase
    end
  end

  // Valid/ready flops follow directly from the next state.
  always_comb begin
    m_valid_d  = (state_d != StEmpty);
    s_valid_d  = (state_d == StFull);
    in_ready_d = ~s_valid_d;
  end

  // State, valid bits and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Main entry payload: refilled from the input or promoted from skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ctrl_q  <= '0;
      m_flags_q <= '0;
      m_data_q  <= '0;
      m_rd_q    <= '0;
    end else if (m_load_in) begin
      m_ctrl_q  <= in_ctrl;
      m_flags_q <= in_flags;
      m_data_q  <= in_data;
      m_rd_q    <= in_rd;
    end else if (m_load_skid) begin
      m_ctrl_q  <= s_ctrl_q;
      m_flags_q <= s_flags_q;
      m_data_q  <= s_data_q;
      m_rd_q    <= s_rd_q;
    end
  end

  // Skid entry payload: captures the op accepted while M is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ctrl_q  <= '0;
      s_flags_q <= '0;
      s_data_q  <= '0;
      s_rd_q    <= '0;
    end else if (s_load) begin
      s_ctrl_q  <= in_ctrl;
      s_flags_q <= in_flags;
      s_data_q  <= in_data;
      s_rd_q    <= in_rd;
    end
  end

  // Outputs straight from flops; only ctrl is bubble-qualified.
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = m_valid_q;
    out_ctrl  = m_ctrl_q & {CTRL_W{m_valid_q}};
    out_flags = m_flags_q;
    out_data  = m_data_q;
    out_rd    = m_rd_q;
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [1:0]  flush_add;
  logic [16:0] flush_sum;

  // Saturating counters: stalled-output cycles and ops killed by flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    flush_add = 2'd0;
    if (flush) begin
      flush_add = {1'b0, m_valid_q} + {1'b0, s_valid_q};
    end
    flush_sum   = {1'b0, flush_cnt_q} + {15'd0, flush_add};
    flush_cnt_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
  end

  // Counter registers; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stat_stall = stall_cnt_q;
  assign stat_flush = flush_cnt_q;
`endif

endmodule
